// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice (two half adders + OR) walks WIDTH bits LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
`timescale 1ns/1ps

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic ha0_s, ha0_c, ha1_s, ha1_c, fa_c;
    logic last_bit;

    // Full-adder slice on the current LSBs and the stored carry.
    assign ha0_s    = a_q[0] ^ b_q[0];
    assign ha0_c    = a_q[0] & b_q[0];
    assign ha1_s    = ha0_s ^ carry_q;
    assign ha1_c    = ha0_s & carry_q;
    assign fa_c     = ha0_c | ha1_c;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                sum_d   = {ha1_s, sum_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_c;
                // Counter stops at WIDTH-1 so it never wraps for power-of-two widths.
                if (last_bit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_c;
`endif
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16 with a result scoreboard.
`timescale 1ns/1ps

module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;
`ifdef SERIAL_ADDER_OVF_EN
    logic        ovf8, ovf16;
`endif

    int total = 0;
    int bad   = 0;

    logic [8:0]  exp8[$];
    logic [16:0] exp16[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf16)
`endif
    );

    // An empty queue yields X so the following comparison fails.
    function automatic logic [8:0] pop8();
        if (exp8.size() == 0) return 9'bx;
        return exp8.pop_front();
    endfunction

    function automatic logic [16:0] pop16();
        if (exp16.size() == 0) return 17'bx;
        return exp16.pop_front();
    endfunction

    task automatic start_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        exp8.push_back(9'(av) + 9'(bv) + 9'(cv));
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic start_op16(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        a16 = av; b16 = bv; cin16 = cv; start16 = 1'b1;
        exp16.push_back(17'(av) + 17'(bv) + 17'(cv));
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    // Returns edges waited until done and how many sampled cycles showed busy; bounded.
    task automatic wait_done8(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = busy8 ? 1 : 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (busy8 === 1'b1) bcnt++;
        end
    endtask

    task automatic wait_done16(output int cyc);
        cyc = 0;
        while (done16 !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b want 0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %0b want 0", done8); end
        total++; if ({cout8, sum8} !== 9'h000) begin bad++; $display("[TB] FAIL reset_sum8: got %h want 000", {cout8, sum8}); end
        total++; if ({cout16, sum16, busy16, done16} !== 19'h0) begin bad++; $display("[TB] FAIL reset_dut16: got %h want 0", {cout16, sum16, busy16, done16}); end
`ifdef SERIAL_ADDER_OVF_EN
        total++; if (ovf8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %0b want 0", ovf8); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc, bcnt;
        logic [8:0] e;
        start_op8(8'h35, 8'h4A, 1'b0);
        wait_done8(cyc, bcnt);
        total++; if (bcnt !== 8) begin bad++; $display("[TB] FAIL basic_busy_len: got %0d want 8", bcnt); end
        total++; if (cyc !== 8) begin bad++; $display("[TB] FAIL basic_latency: got %0d want 8", cyc); end
        e = pop8();
        total++; if ({cout8, sum8} !== e) begin bad++; $display("[TB] FAIL basic_result: got %h want %h", {cout8, sum8}, e); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_at_done: got %0b want 0", busy8); end
        @(posedge clk); #1;
        total++; if (done8 !== 1'b0) begin bad++; $display("[TB] FAIL basic_done_pulse: got %0b want 0", done8); end
        repeat (5) @(posedge clk);
        #1;
        total++; if ({cout8, sum8} !== 9'h07F) begin bad++; $display("[TB] FAIL basic_hold: got %h want 07f", {cout8, sum8}); end
    endtask

    task automatic test_all_ones();
        int cyc, bcnt;
        logic [8:0] e;
        start_op8(8'hFF, 8'hFF, 1'b1);
        wait_done8(cyc, bcnt);
        e = pop8();
        total++; if ({cout8, sum8} !== e) begin bad++; $display("[TB] FAIL all_ones: got %h want %h", {cout8, sum8}, e); end
        total++; if ({cout8, sum8} !== 9'h1FF) begin bad++; $display("[TB] FAIL all_ones_const: got %h want 1ff", {cout8, sum8}); end
`ifdef SERIAL_ADDER_OVF_EN
        total++; if (ovf8 !== 1'b0) begin bad++; $display("[TB] FAIL all_ones_ovf: got %0b want 0", ovf8); end
`endif
        start_op8(8'h7F, 8'h01, 1'b0);
        wait_done8(cyc, bcnt);
        e = pop8();
        total++; if ({cout8, sum8} !== e) begin bad++; $display("[TB] FAIL signed_edge: got %h want %h", {cout8, sum8}, e); end
`ifdef SERIAL_ADDER_OVF_EN
        total++; if (ovf8 !== 1'b1) begin bad++; $display("[TB] FAIL signed_edge_ovf: got %0b want 1", ovf8); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int dcnt, dn;
        logic [8:0] e;
        dcnt = 0; dn = -1;
        start_op8(8'h12, 8'h34, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        total++; if (busy8 !== 1'b1) begin bad++; $display("[TB] FAIL ignore_busy: got %0b want 1", busy8); end
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) begin
                dcnt++;
                if (dcnt == 1) begin
                    dn = n;
                    e = pop8();
                    total++; if ({cout8, sum8} !== e) begin bad++; $display("[TB] FAIL ignore_result: got %h want %h", {cout8, sum8}, e); end
                end
            end
        end
        total++; if (dcnt !== 1) begin bad++; $display("[TB] FAIL ignore_done_count: got %0d want 1", dcnt); end
        total++; if (dn !== 4) begin bad++; $display("[TB] FAIL ignore_latency: got %0d want 4", dn); end
    endtask

    task automatic test_back_to_back();
        int dcnt, last;
        logic [8:0] e;
        dcnt = 0; last = 0;
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        repeat (3) exp8.push_back(9'h002);
        for (int n = 1; n <= 40 && dcnt < 3; n++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) begin
                dcnt++;
                if (dcnt == 3) start8 = 1'b0;
                e = pop8();
                total++; if ({cout8, sum8} !== e) begin bad++; $display("[TB] FAIL b2b_result%0d: got %h want %h", dcnt, {cout8, sum8}, e); end
                if (last > 0) begin
                    total++; if (n - last !== 9) begin bad++; $display("[TB] FAIL b2b_period: got %0d want 9", n - last); end
                end else begin
                    total++; if (n !== 9) begin bad++; $display("[TB] FAIL b2b_first: got %0d want 9", n); end
                end
                last = n;
            end
        end
        start8 = 1'b0;
        total++; if (dcnt !== 3) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 3", dcnt); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle: got %0b want 0", busy8); end
        exp8.delete();
    endtask

    task automatic test_reset_mid();
        int cyc, bcnt;
        logic [8:0] e;
        start_op8(8'h55, 8'h66, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if ({busy8, done8} !== 2'b00) begin bad++; $display("[TB] FAIL midrst_flags: got %b want 00", {busy8, done8}); end
        total++; if ({cout8, sum8} !== 9'h000) begin bad++; $display("[TB] FAIL midrst_sum: got %h want 000", {cout8, sum8}); end
        exp8.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_op8(8'h10, 8'h20, 1'b0);
        wait_done8(cyc, bcnt);
        total++; if (cyc !== 8) begin bad++; $display("[TB] FAIL midrst_latency: got %0d want 8", cyc); end
        e = pop8();
        total++; if ({cout8, sum8} !== e) begin bad++; $display("[TB] FAIL midrst_result: got %h want %h", {cout8, sum8}, e); end
        total++; if (sum8 !== 8'h30) begin bad++; $display("[TB] FAIL midrst_const: got %h want 30", sum8); end
        @(posedge clk); #1;
    endtask

    task automatic test_random8();
        int cyc, bcnt;
        logic [8:0] e;
        for (int i = 0; i < 1000; i++) begin
            start_op8(8'($urandom), 8'($urandom), 1'($urandom));
            wait_done8(cyc, bcnt);
            e = pop8();
            total++; if ({cout8, sum8} !== e) begin bad++; $display("[TB] FAIL rand8_%0d: got %h want %h", i, {cout8, sum8}, e); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random16();
        int cyc;
        logic [16:0] e;
        for (int i = 0; i < 1000; i++) begin
            start_op16(16'($urandom), 16'($urandom), 1'($urandom));
            wait_done16(cyc);
            e = pop16();
            total++; if ({cout16, sum16} !== e || cyc !== 16) begin
                bad++;
                $display("[TB] FAIL rand16_%0d: got %h after %0d edges want %h after 16", i, {cout16, sum16}, cyc, e);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random8();
        test_random16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that sits directly downstream of the half-adder/full-adder cells. It accepts two WIDTH-bit operands plus carry-in and adds them one bit per clock through a single full-adder slice, built as two half adders plus an OR. The carry is kept in a flip-flop between bits. A start/busy/done handshake frames each operation, and the result stays on the outputs until the next operation is accepted.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on the rising edge.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  result, (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- FSM states: IDLE, ADD, DONE. Encoding is free.
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, bit counter=0, carry flip-flop=0.
- IDLE or DONE with start=1: the edge loads the A/B shift registers from a/b, loads the carry flip-flop from cin, clears the counter, and moves to ADD.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: move to IDLE.
- ADD, each edge:
  - Full-adder slice computes s = A[0]^B[0]^c and c' = A[0]&B[0] | c&(A[0]^B[0]).
  - s shifts into the MSB of the sum shift register, which shifts right.
  - A and B shift right; the carry flip-flop takes c'; the counter increments.
- ADD on the edge where counter = WIDTH-1: process the last bit, move to DONE, update cout with the final carry.
- start during ADD is ignored. No queuing, and no change to the operands in flight.
- sum and cout change only during ADD. They hold their value through DONE and IDLE until the next accepted start.
- Counter width is clog2(WIDTH) bits. It never wraps in normal operation.
- Every operand value is legal, including all-ones + all-ones + cin=1: sum = 2^WIDTH-1, cout=1.

## Timing
- Accepting edge k: busy=1 from edge k through edge k+WIDTH-1, i.e. for exactly WIDTH cycles.
- Edge k+WIDTH: busy=0, done=1, sum/cout/ovf final.
- Edge k+WIDTH+1: done=0.
- Latency from the accepting edge to done is WIDTH cycles.
- Back-to-back operation: start held high during DONE is accepted on edge k+WIDTH+1. Sustained throughput is one operation every WIDTH+1 cycles.
- sum bits are partially updated while busy=1. Consumers sample only while done=1 or afterwards.
- rst_n asserted mid-ADD: the operation is aborted immediately and all outputs take their reset values. The first edge after deassertion can accept start.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Adds the output port ovf, registered on the final ADD edge.
  - ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - ovf holds with sum and resets to 0.
- Not defined: no ovf port and no associated logic; behaviour is otherwise identical.

## Test plan
- Reset, then WIDTH=8, a=8'h35, b=8'h4A, cin=0, start one cycle -> busy for 8 cycles; done pulse on the 8th edge with sum=8'h7F, cout=0; sum still 8'h7F 5 cycles later.
- a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. With the macro: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
- start pulsed again on the 3rd busy cycle with different operands -> ignored; result matches the first operands; done pulses exactly once.
- start held high continuously with a=8'h01, b=8'h01 -> done every 9 cycles, sum=8'h02 each time.
- rst_n low for one cycle during the 4th busy cycle -> busy, done, sum and cout are 0 immediately; a new operation 8'h10+8'h20 then yields 8'h30.
- Random sweep of 1000 operand/cin triples at WIDTH=8 and WIDTH=16 -> {cout,sum} equals a+b+cin every time.
